fft8_twiddle_stage: RTL and testbench

//  Streaming twiddle-multiply stage of the 8-point FFT, between the radix-2 butterfly stages.
//  - Takes one complex sample per accepted beat, tagged with twiddle index k.
//  - Multiplies the sample by W8^k = exp(-j*2*pi*k/8), k = 0..3.
//  - 1/sqrt(2) scaling uses two div_sqrt_2 instances (shift-add); there is no multiplier.
//  - 2-stage pipeline with valid/ready backpressure.

---
 rtl/fft8_twiddle_stage_pkg.sv | 30 +++
 rtl/div_sqrt_2.sv | 18 +
 rtl/fft8_twiddle_stage.sv | 136 +++++++++++++
 tb/tb_fft8_twiddle_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft8_twiddle_stage_pkg.sv
// Shared constants and saturating arithmetic helper for the 8-point FFT stages.
// Holds twiddle index codes and tag width used across butterfly/twiddle stages.
package fft8_twiddle_stage_pkg;

  localparam logic [1:0] TW_K0 = 2'd0;
  localparam logic [1:0] TW_K1 = 2'd1;
  localparam logic [1:0] TW_K2 = 2'd2;
  localparam logic [1:0] TW_K3 = 2'd3;

  localparam int FFT8_TAG_W = 3;

  // x+y or x-y on sign-extended operands, clamped to a w-bit signed range
  function automatic logic signed [31:0] fft8_sat_addsub(
    input logic signed [31:0] x,
    input logic signed [31:0] y,
    input logic               sub,
    input int                 w
  );
    logic signed [31:0] r;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    r  = sub ? x - y : x + y;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/div_sqrt_2.sv
// Multiplier-free x/sqrt(2): x*(1/2 + 1/8 + 1/16 + 1/64), each term an
// arithmetic right shift, summed modulo 2**W.
module div_sqrt_2 #(
  parameter int N = 3
) (
  input  logic [2**N-1:0] x,
  output logic [2**N-1:0] y
);

  localparam int W = 2 ** N;

  logic signed [W-1:0] xs;

  assign xs = x;
  assign y  = (xs >>> 1) + (xs >>> 3)
            + (xs >>> 4) + (xs >>> 6);

endmodule

// File: rtl/fft8_twiddle_stage.sv
// Two-stage twiddle multiply by W8^k, k=0..3, with valid/ready backpressure.
// Define TWIDDLE_SAT_EN for saturating add/sub/negate instead of wrapping.
module fft8_twiddle_stage
  import fft8_twiddle_stage_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2**N-1:0]       in_re,
  input  logic [2**N-1:0]       in_im,
  input  logic [1:0]            in_k,
  input  logic [FFT8_TAG_W-1:0] in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2**N-1:0]       out_re,
  output logic [2**N-1:0]       out_im,
  output logic [FFT8_TAG_W-1:0] out_tag
);

  localparam int W = 2 ** N;

  logic                  en;
  logic                  v1;
  logic [1:0]            k1;
  logic [FFT8_TAG_W-1:0] tag1;
  logic [W-1:0]          a1;
  logic [W-1:0]          b1;
  logic [W-1:0]          s1;
  logic [W-1:0]          d1;
  logic [W-1:0]          s_nx;
  logic [W-1:0]          d_nx;
  logic [W-1:0]          ds;
  logic [W-1:0]          dd;
  logic [W-1:0]          re_nx;
  logic [W-1:0]          im_nx;

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

`ifdef TWIDDLE_SAT_EN
  function automatic logic [W-1:0] neg(
    input logic [W-1:0] x
  );
    return W'(fft8_sat_addsub(
      32'sd0, 32'(signed'(x)), 1'b1, W));
  endfunction

  assign s_nx = W'(fft8_sat_addsub(
    32'(signed'(in_re)),
    32'(signed'(in_im)), 1'b0, W));
  assign d_nx = W'(fft8_sat_addsub(
    32'(signed'(in_im)),
    32'(signed'(in_re)), 1'b1, W));
`else
  function automatic logic [W-1:0] neg(
    input logic [W-1:0] x
  );
    return W'(-x);
  endfunction

  assign s_nx = in_re + in_im;
  assign d_nx = in_im - in_re;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      k1   <= '0;
      tag1 <= '0;
      a1   <= '0;
      b1   <= '0;
      s1   <= '0;
      d1   <= '0;
    end else if (en) begin
      v1   <= in_valid;
      k1   <= in_k;
      tag1 <= in_tag;
      a1   <= in_re;
      b1   <= in_im;
      s1   <= s_nx;
      d1   <= d_nx;
    end
  end

  div_sqrt_2 #(.N(N)) u_div_s (
    .x(s1),
    .y(ds)
  );

  div_sqrt_2 #(.N(N)) u_div_d (
    .x(d1),
    .y(dd)
  );

  // divide before negate so -D(s) stays symmetric with D(d)
  always_comb begin
    re_nx = a1;
    im_nx = b1;
    unique case (k1)
      TW_K0: begin
        re_nx = a1;
        im_nx = b1;
      end
      TW_K1: begin
        re_nx = ds;
        im_nx = dd;
      end
      TW_K2: begin
        re_nx = b1;
        im_nx = neg(a1);
      end
      TW_K3: begin
        re_nx = dd;
        im_nx = neg(ds);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= v1;
      out_re    <= re_nx;
      out_im    <= im_nx;
      out_tag   <= tag1;
    end
  end

endmodule

// File: tb/tb_fft8_twiddle_stage.sv
// Bench for fft8_twiddle_stage (N=3, W=8): scoreboard model plus directed
// literal checks; TWIDDLE_SAT_EN selects saturating expectations.
module tb_fft8_twiddle_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_re;
  logic [7:0] in_im;
  logic [1:0] in_k;
  logic [2:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_re;
  logic [7:0] out_im;
  logic [2:0] out_tag;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int re;
    int im;
    int tag;
  } beat_t;

  beat_t expq[$];
  int got_re[$];
  int got_im[$];
  int got_tag[$];
  int got_cyc[$];

  fft8_twiddle_stage #(.N(3)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_re(in_re),
    .in_im(in_im),
    .in_k(in_k),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re(out_re),
    .out_im(out_im),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int fix(int x);
`ifdef TWIDDLE_SAT_EN
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
`else
    int r;
    r = (x + 128) % 256;
    if (r < 0) r = r + 256;
    return r - 128;
`endif
  endfunction

  function automatic int fdiv(int x, int m);
    if (x >= 0) return x / m;
    return -((-x + m - 1) / m);
  endfunction

  // 1/sqrt(2) ~ 1/2+1/8+1/16+1/64, each partial product floored
  function automatic int dsq(int x);
    return fix(fdiv(x, 2) + fdiv(x, 8)
             + fdiv(x, 16) + fdiv(x, 64));
  endfunction

  function automatic beat_t model(int k, int a, int b, int tag);
    beat_t e;
    int s;
    int d;
    s = fix(a + b);
    d = fix(b - a);
    e.tag = tag;
    case (k)
      0: begin e.re = a;      e.im = b;            end
      1: begin e.re = dsq(s); e.im = dsq(d);       end
      2: begin e.re = b;      e.im = fix(-a);      end
      default: begin e.re = dsq(d); e.im = fix(-dsq(s)); end
    endcase
    return e;
  endfunction

  task automatic chk(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  logic [7:0] p_re;
  logic [7:0] p_im;
  logic [2:0] p_tag;
  logic       p_stall = 1'b0;

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      expq.delete();
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        chk("hold_re", int'(out_re), int'(p_re));
        chk("hold_im", int'(out_im), int'(p_im));
        chk("hold_tag", int'(out_tag), int'(p_tag));
      end
      if (out_valid && !out_ready)
        chk("stall_in_ready", int'(in_ready), 0);
      if (out_valid && out_ready) begin
        got_re.push_back(int'($signed(out_re)));
        got_im.push_back(int'($signed(out_im)));
        got_tag.push_back(int'(out_tag));
        got_cyc.push_back(cyc);
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat actual=tag%0d required=none",
                   out_tag);
        end else begin
          e = expq.pop_front();
          chk("sb_re", int'($signed(out_re)), e.re);
          chk("sb_im", int'($signed(out_im)), e.im);
          chk("sb_tag", int'(out_tag), e.tag);
        end
      end
      if (in_valid && in_ready)
        expq.push_back(model(int'(in_k), int'($signed(in_re)),
                             int'($signed(in_im)), int'(in_tag)));
      p_stall = out_valid && !out_ready;
      p_re    = out_re;
      p_im    = out_im;
      p_tag   = out_tag;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int k, int a, int b, int tag);
    int n;
    bit acc;
    n        = 0;
    in_k     = 2'(k);
    in_re    = 8'(a);
    in_im    = 8'(b);
    in_tag   = 3'(tag);
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=stuck required=accept");
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int er[4];
    int ei[4];
    er = '{32, 45, 32, 0};
    ei = '{32, 0, -32, -45};

    // reset held with a beat presented
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_k      = 2'd1;
    in_re     = 8'd50;
    in_im     = 8'd20;
    in_tag    = 3'd5;
    repeat (3) begin
      tick();
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_re", int'(out_re), 0);
      chk("rst_out_im", int'(out_im), 0);
      chk("rst_out_tag", int'(out_tag), 0);
    end
    rst = 1'b0;
    chk("first_in_ready", int'(in_ready), 1);
    in_k   = 2'd0;
    in_re  = 8'd5;
    in_im  = -8'sd3;
    in_tag = 3'd1;
    tick();
    in_valid = 1'b0;
    chk("lat1_out_valid", int'(out_valid), 0);
    tick();
    chk("lat2_out_valid", int'(out_valid), 1);
    chk("lat2_re", int'($signed(out_re)), 5);
    chk("lat2_im", int'($signed(out_im)), -3);
    chk("lat2_tag", int'(out_tag), 1);
    repeat (2) tick();

    // all four twiddles back to back
    base = got_re.size();
    for (int k = 0; k < 4; k++) send(k, 32, 32, k + 2);
    repeat (4) tick();
    chk("tw_count", got_re.size() - base, 4);
    if (got_re.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("tw_re", got_re[base + i], er[i]);
        chk("tw_im", got_im[base + i], ei[i]);
        chk("tw_tag", got_tag[base + i], i + 2);
      end
      for (int i = 1; i < 4; i++)
        chk("tw_gap", got_cyc[base + i] - got_cyc[base + i - 1], 1);
    end

    // backpressure mid-stream
    base = got_re.size();
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(i % 4, 17 * i - 40, 90 - 23 * i, i);
      end
      begin
        repeat (3) tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
      end
    join
    repeat (6) tick();
    chk("bp_count", got_re.size() - base, 6);
    if (got_re.size() >= base + 6)
      for (int i = 0; i < 6; i++)
        chk("bp_order", got_tag[base + i], i);

    // overflow corners
    base = got_re.size();
    send(1, 100, 100, 3);
    send(2, -128, 0, 4);
    send(3, 10, -50, 5);
    repeat (4) tick();
    chk("ovf_count", got_re.size() - base, 3);
    if (got_re.size() >= base + 3) begin
`ifdef TWIDDLE_SAT_EN
      chk("ovf_k1_re", got_re[base], 86);
      chk("ovf_k2_im", got_im[base + 1], 127);
`else
      chk("ovf_k1_re", got_re[base], -40);
      chk("ovf_k2_im", got_im[base + 1], -128);
`endif
      chk("ovf_k1_im", got_im[base], 0);
      chk("ovf_k2_re", got_re[base + 1], 0);
      chk("neg_k3_re", got_re[base + 2], -43);
      chk("neg_k3_im", got_im[base + 2], 29);
    end

    // reset with two beats in flight
    out_ready = 1'b1;
    send(0, 11, 22, 6);
    out_ready = 1'b0;
    send(3, 10, -50, 7);
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    chk("rst_mid_out_valid", int'(out_valid), 0);
    base = got_re.size();
    repeat (6) tick();
    chk("rst_mid_no_beats", got_re.size() - base, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
